// File: rtl/alu_rv_pkg.sv
// Shared definitions for the RV32I ALU control-transfer blocks:
// opcode encodings, default widths and the stage-1 control payload.
package alu_rv_pkg;

  localparam int XLEN_DEFAULT        = 32;
  localparam int IALIGN_DEFAULT      = 32;
  localparam int LINK_OFFSET_DEFAULT = 4;

  // Control-transfer opcode as delivered by decode.
  typedef enum logic [2:0] {
    CT_JAL  = 3'd0,
    CT_JALR = 3'd1,
    CT_BEQ  = 3'd2,
    CT_BNE  = 3'd3,
    CT_BLT  = 3'd4,
    CT_BGE  = 3'd5,
    CT_BLTU = 3'd6,
    CT_BGEU = 3'd7
  } ct_op_e;

  // Width-independent part of the stage-1 payload: the opcode plus the
  // three compare flags resolved from rs1/rs2 in the first stage.
  typedef struct packed {
    ct_op_e op;
    logic   eq;
    logic   lt;
    logic   ltu;
  } s1_ctrl_t;

  // Unconditional jumps write the link register; branches never do.
  function automatic logic is_jump(input ct_op_e op);
    return (op == CT_JAL) || (op == CT_JALR);
  endfunction

endpackage

// File: rtl/alu_branch_compare.sv
// Combinational rs1/rs2 comparator producing equal, signed-less-than and
// unsigned-less-than. Shared by any ALU block that needs branch conditions.
module alu_branch_compare #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_eq,
  output logic            o_lt,
  output logic            o_ltu
);

  assign o_eq  = (i_rs1 == i_rs2);
  assign o_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign o_ltu = (i_rs1 < i_rs2);

endmodule

// File: rtl/alu_control_transfer.sv
// Two-stage RV32I control-transfer unit (JAL, JALR, conditional branches).
// Stage 1 captures the opcode, compare flags, link value and target;
// stage 2 resolves taken/next_pc/misaligned/rd and holds the result for the
// consumer. Both stages use valid/ready flow control; flush kills everything
// in flight on the next edge.
module alu_control_transfer
  import alu_rv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int IALIGN      = IALIGN_DEFAULT,
  parameter int LINK_OFFSET = LINK_OFFSET_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] immediate,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] rd_value,
  output logic            rd_write,
  output logic            taken,
  output logic            misaligned
);

  // Only 32-bit instruction alignment traps on target[1]; with the C
  // extension every even address is legal and JALR already clears bit 0.
  localparam logic CHECK_ALIGN = (IALIGN == 32);

  // ---------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------
  logic w_s1_advance;
  logic w_s2_advance;
  logic w_accept;

  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_advance = ~r_s2_valid | out_ready;
  assign w_s1_advance = ~r_s1_valid | w_s2_advance;
  assign in_ready     = w_s1_advance & ~flush;
  assign w_accept     = in_valid & in_ready;

  // ---------------------------------------------------------------------
  // Stage 1 combinational: compare flags, link and target
  // ---------------------------------------------------------------------
  ct_op_e          w_op;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_link;

  assign w_op = ct_op_e'(op);

  alu_branch_compare #(
    .XLEN (XLEN)
  ) u_branch_compare (
    .i_rs1 (rs1_value),
    .i_rs2 (rs2_value),
    .o_eq  (w_eq),
    .o_lt  (w_lt),
    .o_ltu (w_ltu)
  );

  // All adds wrap modulo 2^XLEN; overflow is architecturally invisible.
  assign w_jalr_sum = rs1_value + immediate;
  assign w_target   = (w_op == CT_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                        : (pc + immediate);
  assign w_link     = pc + XLEN'(LINK_OFFSET);

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  s1_ctrl_t        r_s1_ctrl;
  logic [XLEN-1:0] r_s1_pc;
  logic [XLEN-1:0] r_s1_link;
  logic [XLEN-1:0] r_s1_target;

  // Stage-1 valid bit and payload capture on an accepted request.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the two stages shift as a real pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_ctrl   <= '0;
      r_s1_pc     <= '0;
      r_s1_link   <= '0;
      r_s1_target <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_advance) begin
        r_s1_valid <= w_accept;
      end
      if (w_accept) begin
        r_s1_ctrl.op  <= w_op;
        r_s1_ctrl.eq  <= w_eq;
        r_s1_ctrl.lt  <= w_lt;
        r_s1_ctrl.ltu <= w_ltu;
        r_s1_pc       <= pc;
        r_s1_link     <= w_link;
        r_s1_target   <= w_target;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 combinational: resolve the transfer from the stage-1 payload
  // ---------------------------------------------------------------------
  logic            w_taken;
  logic            w_is_jump;
  logic            w_misaligned;
  logic            w_rd_write;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_rd_value;

  // Select the branch condition, then derive next_pc, trap flag and rd.
  // NOTE: every output gets a default before the case so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    w_taken   = 1'b0;
    w_is_jump = is_jump(r_s1_ctrl.op);
    case (r_s1_ctrl.op)
      CT_JAL,
      CT_JALR: w_taken = 1'b1;
      CT_BEQ:  w_taken = r_s1_ctrl.eq;
      CT_BNE:  w_taken = ~r_s1_ctrl.eq;
      CT_BLT:  w_taken = r_s1_ctrl.lt;
      CT_BGE:  w_taken = ~r_s1_ctrl.lt;
      CT_BLTU: w_taken = r_s1_ctrl.ltu;
      CT_BGEU: w_taken = ~r_s1_ctrl.ltu;
      default: w_taken = 1'b0;
    endcase
    // A misaligned target is still reported so the trap unit can log it.
    w_next_pc    = w_taken ? r_s1_target : (r_s1_pc + XLEN'(4));
    w_misaligned = w_taken & CHECK_ALIGN & r_s1_target[1];
    w_rd_write   = w_is_jump & ~w_misaligned;
    w_rd_value   = w_is_jump ? r_s1_link : '0;
  end

  // ---------------------------------------------------------------------
  // Stage 2 registers (the visible result)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] r_next_pc;
  logic [XLEN-1:0] r_rd_value;
  logic            r_rd_write;
  logic            r_taken;
  logic            r_misaligned;

  // Stage-2 valid bit and result capture; results hold while stalled.
  // NOTE: result registers are reset too, because consumers may look at
  // them straight out of reset and must see zeros rather than X.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_next_pc    <= '0;
      r_rd_value   <= '0;
      r_rd_write   <= 1'b0;
      r_taken      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_advance) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_advance && r_s1_valid) begin
        r_next_pc    <= w_next_pc;
        r_rd_value   <= w_rd_value;
        r_rd_write   <= w_rd_write;
        r_taken      <= w_taken;
        r_misaligned <= w_misaligned;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign next_pc    = r_next_pc;
  assign rd_value   = r_rd_value;
  assign rd_write   = r_rd_write;
  assign taken      = r_taken;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_alu_control_transfer.sv
// Self-checking bench for alu_control_transfer: directed test-plan cases,
// a stall/flush/reset sequence and a randomized stream, all compared every
// cycle against a transaction-level reference (a queue of expected results).
module tb_alu_control_transfer;

  localparam int XLEN        = 32;
  localparam int IALIGN      = 32;
  localparam int LINK_OFFSET = 4;

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] immediate;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] rd_value;
  logic            rd_write;
  logic            taken;
  logic            misaligned;

  alu_control_transfer #(
    .XLEN        (XLEN),
    .IALIGN      (IALIGN),
    .LINK_OFFSET (LINK_OFFSET)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .pc         (pc),
    .rs1_value  (rs1_value),
    .rs2_value  (rs2_value),
    .immediate  (immediate),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .next_pc    (next_pc),
    .rd_value   (rd_value),
    .rd_write   (rd_write),
    .taken      (taken),
    .misaligned (misaligned)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference: what an instruction must resolve to, from the ISA rules.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [31:0] next_pc;
    logic [31:0] rd_value;
    logic        rd_write;
    logic        taken;
    logic        mis;
    int          cyc;
  } exp_t;

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
    exp_t        e;
    logic [31:0] tgt;
    logic        jump;
    jump = (o == 3'd0) || (o == 3'd1);
    case (o)
      3'd2:    e.taken = (a == b);
      3'd3:    e.taken = (a != b);
      3'd4:    e.taken = ($signed(a) <  $signed(b));
      3'd5:    e.taken = ($signed(a) >= $signed(b));
      3'd6:    e.taken = (a <  b);
      3'd7:    e.taken = (a >= b);
      default: e.taken = 1'b1;
    endcase
    tgt        = (o == 3'd1) ? ((a + imm) & 32'hFFFF_FFFE) : (p + imm);
    e.next_pc  = e.taken ? tgt : p + 32'd4;
    e.mis      = e.taken && (IALIGN == 32) && tgt[1];
    e.rd_write = jump && !e.mis;
    e.rd_value = jump ? p + 32'(LINK_OFFSET) : 32'd0;
    e.cyc      = 0;
    return e;
  endfunction

  // ---------------------------------------------------------------------
  // Compare process: every cycle, at the falling edge.
  // Requests in flight live in a queue; the head becomes visible exactly two
  // cycles after acceptance (nothing older can block it), at most two are
  // held, flush and reset empty the queue.
  // ---------------------------------------------------------------------
  exp_t q[$];
  exp_t e_new;
  int   cyc = 0;
  logic exp_ready;
  logic exp_ov;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      q.delete();
    end else begin
      exp_ready = !flush && ((q.size() < 2) || out_ready);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      exp_ov = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      if (exp_ov) begin
        check("next_pc",    next_pc,    q[0].next_pc);
        check("rd_value",   rd_value,   q[0].rd_value);
        check("rd_write",   {31'd0, rd_write},   {31'd0, q[0].rd_write});
        check("taken",      {31'd0, taken},      {31'd0, q[0].taken});
        check("misaligned", {31'd0, misaligned}, {31'd0, q[0].mis});
        if (out_ready) void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && exp_ready) begin
        e_new     = model(op, pc, rs1_value, rs2_value, immediate);
        e_new.cyc = cyc;
        q.push_back(e_new);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver helpers. Called at posedge+1; return at posedge+1 after the
  // accepting edge with in_valid dropped (a following send re-raises it).
  // ---------------------------------------------------------------------
  task automatic send(input logic [2:0] o, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm);
    bit acc = 0;
    in_valid  = 1'b1;
    op        = o;
    pc        = p;
    rs1_value = a;
    rs2_value = b;
    immediate = imm;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1;
        break;
      end
    end
    check("send_accept_timeout", {31'd0, acc}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clock);
    #1;
    check("drain_queue_empty", q.size(), 32'd0);
  endtask

  task automatic pin_model();
    exp_t m;
    m = model(3'd0, 32'h100, 32'd0, 32'd0, 32'h20);
    check("pin_jal_next", m.next_pc, 32'h120);
    check("pin_jal_rd",   m.rd_value, 32'h104);
    check("pin_jal_wr",   {31'd0, m.rd_write}, 32'd1);
    m = model(3'd1, 32'h300, 32'h2001, 32'd0, 32'h4);
    check("pin_jalr_next", m.next_pc, 32'h2004);
    check("pin_jalr_rd",   m.rd_value, 32'h304);
    m = model(3'd1, 32'h300, 32'h2001, 32'd0, 32'h6);
    check("pin_jalr_mis",   {31'd0, m.mis}, 32'd1);
    check("pin_jalr_mis_wr",{31'd0, m.rd_write}, 32'd0);
    check("pin_jalr_mis_pc",m.next_pc, 32'h2006);
    m = model(3'd4, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    check("pin_blt_taken", {31'd0, m.taken}, 32'd1);
    check("pin_blt_next",  m.next_pc, 32'h38);
    m = model(3'd6, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    check("pin_bltu_taken", {31'd0, m.taken}, 32'd0);
    check("pin_bltu_next",  m.next_pc, 32'h44);
    m = model(3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8);
    check("pin_wrap_next", m.next_pc, 32'h4);
  endtask

  logic [31:0] r_imm;
  bit          last_acc;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    pc        = '0;
    rs1_value = '0;
    rs2_value = '0;
    immediate = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_next_pc",   next_pc, 32'd0);
    check("reset_rd_value",  rd_value, 32'd0);
    check("reset_flags",     {28'd0, rd_write, taken, misaligned, out_valid}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;

    pin_model();

    // JAL with literal latency/value checks on the DUT itself.
    send(3'd0, 32'h100, 32'd0, 32'd0, 32'h20);
    @(negedge clock);
    check("jal_lat1_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check("jal_lat2_out_valid", {31'd0, out_valid}, 32'd1);
    check("jal_next_pc",  next_pc, 32'h120);
    check("jal_rd_value", rd_value, 32'h104);
    check("jal_flags",    {29'd0, rd_write, taken, misaligned}, 32'b110);
    @(posedge clock);
    #1;

    // JALR aligned / misaligned, BLT vs BLTU (model-checked every cycle).
    send(3'd1, 32'h300, 32'h2001, 32'd0, 32'h4);
    send(3'd1, 32'h300, 32'h2001, 32'd0, 32'h6);
    send(3'd4, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    send(3'd6, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
    drain();

    // Four back-to-back BEQs with the consumer stalled.
    out_ready = 1'b0;
    fork
      begin
        send(3'd2, 32'h1000, 32'd5, 32'd5, 32'h10);
        send(3'd2, 32'h1004, 32'd5, 32'd6, 32'h10);
        send(3'd2, 32'h1008, 32'd7, 32'd7, 32'hFFFF_FFF0);
        send(3'd2, 32'h100C, 32'd1, 32'd2, 32'h8);
      end
      begin
        repeat (3) @(negedge clock);
        check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two requests in flight and a third one offered.
    out_ready = 1'b0;
    send(3'd3, 32'h2000, 32'd1, 32'd2, 32'h40);
    send(3'd5, 32'h2004, 32'd3, 32'd2, 32'h40);
    in_valid = 1'b1;
    op       = 3'd0;
    pc       = 32'h3000;
    flush    = 1'b1;
    @(negedge clock);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("flush_out_valid_1", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check("flush_out_valid_2", {31'd0, out_valid}, 32'd0);
    @(posedge clock);
    #1;

    // Randomized stream with stalls and occasional flushes.
    last_acc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op       = 3'($urandom_range(0, 7));
        pc       = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC))
                                               : ($urandom & 32'hFFFF_FFFC);
        rs1_value = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                : $urandom;
        rs2_value = ($urandom_range(0, 3) == 0) ? rs1_value : $urandom;
        r_imm     = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) r_imm = -r_imm;
        immediate = ($urandom_range(0, 7) == 0) ? $urandom : r_imm;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(negedge clock);
      last_acc = in_valid && in_ready;
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-stream, then a wrapping JAL.
    send(3'd0, 32'h500, 32'd0, 32'd0, 32'h80);
    send(3'd7, 32'h504, 32'd9, 32'd3, 32'h10);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_next_pc",   next_pc, 32'd0);
    check("async_reset_rd_value",  rd_value, 32'd0);
    check("async_reset_flags",     {29'd0, rd_write, taken, misaligned}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clock);
    #1;
    send(3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8);
    @(negedge clock);
    @(negedge clock);
    check("wrap_out_valid", {31'd0, out_valid}, 32'd1);
    check("wrap_next_pc",   next_pc, 32'h4);
    @(posedge clock);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
